cam_emu_tx: RTL and testbench

- Camera parallel interface (CPI) source that emulates an 8-bit image sensor, driving the SoC camera pads (pclk, vsync, hsync/href, data[7:0]) on the FPGA emulation target.
- Lets the uDMA camera receiver be exercised on the board without a physical sensor.
- Generates frames with configurable geometry and a selectable test pattern.
- Reports frame completion and a running frame count.

---
 rtl/cam_emu_tx_if.sv | 11 +
 rtl/cam_emu_tx.sv | 188 ++++++++++++++++++
 tb/tb_cam_emu_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_emu_tx_if.sv
// Camera parallel interface pad bundle: pixel clock, frame/line syncs and pixel byte.
// The emulator drives it through the master modport; a receiver model uses slave.
interface cam_emu_tx_if;
  logic       cam_pclk_o;
  logic       cam_vsync_o;
  logic       cam_hsync_o;
  logic [7:0] cam_data_o;

  modport master (output cam_pclk_o, output cam_vsync_o, output cam_hsync_o, output cam_data_o);
  modport slave  (input  cam_pclk_o, input  cam_vsync_o, input  cam_hsync_o, input  cam_data_o);
endinterface

// File: rtl/cam_emu_tx.sv
// 8-bit CPI image-sensor emulator: free-running pclk, vsync/href framing and
// selectable test patterns, with frame-done pulse and frame counter.
module cam_emu_tx #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_BLANK  = 4,
    parameter int unsigned VS_LEN   = 8,
    parameter int unsigned PCLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        pattern_i,
    input  logic [7:0]        const_i,
    cam_emu_tx_if.master      cpi_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned COL_MAX = (H_TOTAL > VS_LEN) ? H_TOTAL : VS_LEN;
    localparam int unsigned ROW_MAX = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int unsigned COL_W   = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
    localparam int unsigned ROW_W   = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
    localparam int unsigned DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] H_ACT    = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] VS_LAST  = COL_W'(VS_LEN - 1);
    localparam logic [ROW_W-1:0] VA_LAST  = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0] VB_LAST  = ROW_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, VSYNC, VBLANK, LINE} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pclk_q, pclk_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [1:0]        pat_q, pat_d;
    logic [7:0]        const_q, const_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              div_last, step, start;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            bcnt_q  <= '0;
            pat_q   <= '0;
            const_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bcnt_q  <= bcnt_d;
            pat_q   <= pat_d;
            const_q <= const_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        div_last = (div_q == DIV_LAST);
        div_d    = div_last ? '0 : div_q + DIV_W'(1);
        pclk_d   = div_last ? ~pclk_q : pclk_q;
        // The falling pclk edge is the only point where framing may move,
        // so outputs are settled a full half-period before the receiver samples.
        step     = div_last & pclk_q;
        start    = 1'b0;
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        bcnt_d   = bcnt_q;
        pat_d    = pat_q;
        const_d  = const_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        vsync_d  = vsync_q;
        href_d   = href_q;
        data_d   = data_q;
        busy_d   = busy_q;

        if (step) begin
            unique case (state_q)
                IDLE: start = en_i;
                VSYNC: begin
                    if (col_q == VS_LAST) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = (V_BLANK == 0) ? LINE : VBLANK;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                VBLANK: begin
                    if (col_q == H_LAST) begin
                        col_d = '0;
                        if (row_q == VB_LAST) begin
                            row_d   = '0;
                            state_d = LINE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                LINE: begin
                    if (col_q == H_LAST) begin
                        col_d = '0;
                        if (row_q == VA_LAST) begin
                            done_d  = 1'b1;
                            cnt_d   = cnt_q + 16'd1;
                            state_d = IDLE;
                            start   = en_i;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start) begin
                state_d = VSYNC;
                col_d   = '0;
                row_d   = '0;
                bcnt_d  = '0;
                pat_d   = pattern_i;
                const_d = const_i;
            end

            // Pad outputs reflect the state being entered on this step.
            vsync_d = (state_d == VSYNC);
            href_d  = (state_d == LINE) && (col_d < H_ACT);
            busy_d  = (state_d != IDLE);
            data_d  = '0;
            if (href_d) begin
                unique case (pat_q)
                    2'd0: begin
                        data_d = bcnt_q;
                        bcnt_d = bcnt_q + 8'd1;
                    end
                    2'd1: data_d = 8'(col_d);
                    2'd2: data_d = 8'(row_d);
                    default: data_d = const_q;
                endcase
            end
        end
    end

    assign cpi_o.cam_pclk_o  = pclk_q;
    assign cpi_o.cam_vsync_o = vsync_q;
    assign cpi_o.cam_hsync_o = href_q;
    assign cpi_o.cam_data_o  = data_q;
    assign busy_o            = busy_q;
    assign frame_done_o      = done_q;
    assign frame_cnt_o       = cnt_q;

endmodule

// File: tb/tb_cam_emu_tx.sv
// Bench for cam_emu_tx: per-pclk-period comparison against an expected frame
// stream built from the framing rules, plus reset, idle and back-to-back checks.
module tb_cam_emu_tx;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 3;
    localparam int unsigned VB = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned HT = HA + HB;
    localparam int unsigned FLEN = VS + (VB + VA) * HT;
    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [1:0]  pattern_i;
    logic [7:0]  const_i;
    logic        busy_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;

    cam_emu_tx_if cam ();

    cam_emu_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .V_BLANK(VB), .VS_LEN(VS), .PCLK_DIV(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i),
        .pattern_i(pattern_i), .const_i(const_i),
        .cpi_o(cam), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
    );

    always #(CLK_P / 2) clk = ~clk;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] d;
    } pix_t;

    pix_t    exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      done_tally = 0;
    int      exp_done = 0;
    int      exp_cnt = 0;
    time     t_last_done;
    bit      t_valid = 0;

    always @(negedge clk) if (frame_done_o === 1'b1) done_tally++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected pad stream of one frame, one entry per pclk period.
    task automatic build_frame(input logic [1:0] p, input logic [7:0] c);
        logic [7:0] b;
        logic [7:0] d;
        b = 8'd0;
        exp_q.delete();
        for (int i = 0; i < int'(VS); i++) exp_q.push_back('{1'b1, 1'b0, 8'h00});
        for (int i = 0; i < int'(VB * HT); i++) exp_q.push_back('{1'b0, 1'b0, 8'h00});
        for (int r = 0; r < int'(VA); r++) begin
            for (int x = 0; x < int'(HT); x++) begin
                if (x < int'(HA)) begin
                    case (p)
                        2'd0: begin d = b; b = b + 8'd1; end
                        2'd1: d = 8'(x);
                        2'd2: d = 8'(r);
                        default: d = c;
                    endcase
                    exp_q.push_back('{1'b0, 1'b1, d});
                end else begin
                    exp_q.push_back('{1'b0, 1'b0, 8'h00});
                end
            end
        end
    endtask

    task automatic wait_step(output bit ok);
        logic p;
        p = cam.cam_pclk_o;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (p === 1'b1 && cam.cam_pclk_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
            p = cam.cam_pclk_o;
        end
        if (!ok) chk("step_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input logic [1:0] p, input logic [7:0] c,
                               input logic [1:0] np, input logic [7:0] nc,
                               input bit en_next, input bit after_done, input int rst_at);
        bit   ok;
        pix_t e;
        build_frame(p, c);
        for (int i = 0; i < int'(FLEN); i++) begin
            wait_step(ok);
            if (!ok) return;
            e = exp_q[i];
            chk($sformatf("px%0d", i),
                {4'd0, cam.cam_vsync_o, cam.cam_hsync_o, cam.cam_data_o, busy_o, frame_done_o, frame_cnt_o},
                {4'd0, e.vs, e.hr, e.d, 1'b1, (i == 0) ? after_done : 1'b0, 16'(exp_cnt)});
            if (i == 0) begin
                if (after_done && t_valid)
                    chk("done_period", 32'($time - t_last_done), 32'(2 * FLEN * CLK_P));
                t_valid     = after_done;
                t_last_done = $time;
            end
            if (i == 10) begin
                pattern_i = 2'($urandom);
                const_i   = 8'($urandom);
            end
            if (i == 15) en_i = en_next;
            if (i == 20) begin
                pattern_i = np;
                const_i   = nc;
            end
            if (i == rst_at) return;
        end
        exp_cnt  = (exp_cnt + 1) % 65536;
        exp_done = exp_done + 1;
    endtask

    task automatic idle_check();
        bit ok;
        wait_step(ok);
        chk("end_step", {frame_done_o, busy_o, cam.cam_vsync_o, cam.cam_hsync_o, cam.cam_data_o, frame_cnt_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'(exp_cnt)});
        t_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_step(ok);
            chk("idle", {frame_done_o, busy_o, cam.cam_vsync_o, cam.cam_hsync_o, cam.cam_data_o, frame_cnt_o},
                {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'(exp_cnt)});
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {cam.cam_pclk_o, cam.cam_vsync_o, cam.cam_hsync_o, cam.cam_data_o,
                  busy_o, frame_done_o, frame_cnt_o}, 32'd0);
    endtask

    initial begin
        logic [1:0] cur_p, np;
        logic [7:0] cur_c, nc;
        logic       prev_pclk;

        rst_ni = 1'b0; en_i = 1'b0; pattern_i = 2'd0; const_i = 8'h00;
        #3;
        chk_reset("reset_hold0");
        repeat (2) @(negedge clk);
        chk_reset("reset_hold1");
        rst_ni = 1'b1;

        // Idle: pclk toggles every clk, everything else quiet.
        prev_pclk = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_pclk", {31'd0, cam.cam_pclk_o}, {31'd0, ~prev_pclk});
            prev_pclk = cam.cam_pclk_o;
            chk("idle_out", {cam.cam_vsync_o, cam.cam_hsync_o, cam.cam_data_o, busy_o, frame_done_o, frame_cnt_o}, 32'd0);
        end

        // Single pattern-0 frame, en dropped mid-frame.
        en_i = 1'b1;
        check_frame(2'd0, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0, -1);
        idle_check();

        // Back-to-back: pattern 1 twice, constant A5 with a mid-frame change to 3C, then 3C.
        pattern_i = 2'd1; const_i = 8'h00; en_i = 1'b1;
        check_frame(2'd1, 8'h00, 2'd1, 8'h00, 1'b1, 1'b0, -1);
        check_frame(2'd1, 8'h00, 2'd3, 8'hA5, 1'b1, 1'b1, -1);
        check_frame(2'd3, 8'hA5, 2'd3, 8'h3C, 1'b1, 1'b1, -1);
        cur_p = 2'd3; cur_c = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            np = 2'($urandom_range(0, 3));
            nc = 8'($urandom);
            check_frame(cur_p, cur_c, np, nc, (k < 2), 1'b1, -1);
            cur_p = np; cur_c = nc;
        end
        idle_check();

        // Asynchronous reset in the middle of the first active line.
        pattern_i = 2'd0; const_i = 8'h00; en_i = 1'b1;
        check_frame(2'd0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0, int'(VS + VB * HT) + 1);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        chk_reset("async_reset_hold");
        exp_cnt = 0;
        t_valid = 1'b0;
        pattern_i = 2'd0;
        rst_ni = 1'b1;
        check_frame(2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, -1);
        idle_check();

        chk("done_total", 32'(done_tally), 32'(exp_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
